// File: rtl/alu_exec_if.sv
// Start/done handshake and operand/result bundle between the issuing stage and alu_exec.
// The issuing side takes the master modport; alu_exec takes the slave modport.
interface alu_exec_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               Start;
  logic [2:0]         Ctrl;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [SHAMT_W-1:0] Shamt;
  logic [WIDTH-1:0]   Result;
  logic               Zero;
  logic               Busy;
  logic               Done;

  modport master (
    output Start, Ctrl, A, B, Shamt,
    input  Result, Zero, Busy, Done
  );

  modport slave (
    input  Start, Ctrl, A, B, Shamt,
    output Result, Zero, Busy, Done
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: one-cycle arithmetic/logic ops and an iterative one-bit-per-cycle sll.
// Defining ALU_FAST_SHIFT_EN replaces the iterative sll with a single-cycle barrel shifter.
module alu_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic     Clk,
  input  logic     Rst,
  alu_exec_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [0:0]         state_q,  state_d;
  logic [WIDTH-1:0]   sreg_q,   sreg_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q,   zero_d;
  logic               done_q,   done_d;
  logic               start_shift;

  // Single-cycle result for every code that completes straight from IDLE.
  function automatic logic [WIDTH-1:0] alu_comb(
    input logic [2:0]         ctrl,
    input logic [WIDTH-1:0]   a,
    input logic [WIDTH-1:0]   b,
    input logic [SHAMT_W-1:0] shamt
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (ctrl)
      OP_ADD, OP_LW, OP_SW: r = a + b;
      OP_AND:               r = a & b;
      OP_NOR:               r = ~(a | b);
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:               r = b << shamt;
`else
      // Only shifts of 0 or 1 reach here; longer ones go through SHIFT.
      OP_SLL:               r = (shamt == '0) ? b : {b[WIDTH-2:0], 1'b0};
`endif
      OP_BEQ:               r = a - b;
      OP_SLT:               r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:              r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_FAST_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = (bus.Ctrl == OP_SLL) && (bus.Shamt > SHAMT_W'(1));
`endif

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (start_shift) begin
            // The first shift happens on the capture edge so Done lands after Shamt cycles.
            sreg_d  = {bus.B[WIDTH-2:0], 1'b0};
            cnt_d   = bus.Shamt - SHAMT_W'(1);
            state_d = S_SHIFT;
          end else begin
            result_d = alu_comb(bus.Ctrl, bus.A, bus.B, bus.Shamt);
            zero_d   = (result_d == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q > SHAMT_W'(1)) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q - SHAMT_W'(1);
        end else begin
          result_d = {sreg_q[WIDTH-2:0], 1'b0};
          zero_d   = (result_d == '0);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign bus.Result = result_q;
  assign bus.Zero   = zero_q;
  assign bus.Busy   = (state_q == S_SHIFT);
  assign bus.Done   = done_q;

endmodule
